// File: rtl/sdram_port_arbiter.sv
// Two-master arbiter in front of one SDRAM Avalon-MM slave: the display reader (port 0) has
// priority, grants are limited to bounded bursts, and a tag FIFO steers read data back in order.
module sdram_port_arbiter #(
    parameter int MAX_BEATS  = 8,
    parameter int PEND_DEPTH = 16,
    parameter int PEND_LOG2  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_address,
    input  logic        m0_read,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,
    output logic        m0_readdatavalid,
    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,
    output logic        m1_readdatavalid,
    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,
    input  logic        s_readdatavalid
);

    localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t                 state;
    logic [BW-1:0]          beat;
    logic                   tag_mem [PEND_DEPTH];
    logic [PEND_LOG2-1:0]   wr_ptr;
    logic [PEND_LOG2-1:0]   rd_ptr;
    logic [PEND_LOG2:0]     count;

    logic req0, req1;
    logic full, empty;
    logic fwd_read;
    logic accept;
    logic last_beat;
    logic push, pop;
    logic head;

    assign req0  = m0_read;
    assign req1  = m1_read | m1_write;
    assign full  = (count == (PEND_LOG2+1)'(PEND_DEPTH));
    assign empty = (count == '0);

    // Forwarding mux; full only gates reads, so writes still flow with a full tag FIFO.
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        fwd_read       = 1'b0;
        accept         = 1'b0;
        case (state)
            GNT0: begin
                s_address      = m0_address;
                fwd_read       = m0_read;
                s_read         = m0_read & ~full;
                s_byteenable   = 4'hF;
                m0_waitrequest = s_waitrequest | (m0_read & full);
                accept         = req0 & ~m0_waitrequest;
            end
            GNT1: begin
                s_address      = m1_address;
                fwd_read       = m1_read;
                s_read         = m1_read & ~full;
                s_write        = m1_write & ~m1_read;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest | (m1_read & full);
                accept         = req1 & ~m1_waitrequest;
            end
            default: ;
        endcase
    end

    assign last_beat = accept & (beat == BW'(MAX_BEATS - 1));
    assign push      = accept & fwd_read;
    assign pop       = s_readdatavalid & ~empty;
    assign head      = tag_mem[rd_ptr];

    assign m0_readdata      = s_readdata;
    assign m1_readdata      = s_readdata;
    assign m0_readdatavalid = pop & ~head;
    assign m1_readdatavalid = pop & head;

    // On release the other port goes first; only an uncontested holder is re-granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (req0)      state <= GNT0;
                    else if (req1) state <= GNT1;
                end
                GNT0: begin
                    if (!req0 || last_beat) begin
                        beat <= '0;
                        if (req1)      state <= GNT1;
                        else if (req0) state <= GNT0;
                        else           state <= IDLE;
                    end else if (accept) begin
                        beat <= beat + 1'b1;
                    end
                end
                GNT1: begin
                    if (!req1 || last_beat) begin
                        beat <= '0;
                        if (req0)      state <= GNT0;
                        else if (req1) state <= GNT1;
                        else           state <= IDLE;
                    end else if (accept) begin
                        beat <= beat + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= (state == GNT1);
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed vector bench for sdram_port_arbiter: each vector drives one cycle of inputs and
// lists the outputs expected in that cycle before the next rising edge.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address;
    logic        m0_read;
    logic [31:0] m0_readdata;
    logic        m0_waitrequest;
    logic        m0_readdatavalid;
    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic [31:0] m1_readdata;
    logic        m1_waitrequest;
    logic        m1_readdatavalid;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic [31:0] s_readdata;
    logic        s_waitrequest;
    logic        s_readdatavalid;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.MAX_BEATS(8), .PEND_DEPTH(16), .PEND_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_readdata(m0_readdata),
        .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_readdata(m1_readdata),
        .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .s_readdatavalid(s_readdatavalid)
    );

    typedef struct {
        bit rst, m0r, m1r, m1w, sw, srdv;
        bit ep;                                   // port whose address/be should reach s_*
        bit e_m0w, e_m1w, e_sr, e_sw, e_m0v, e_m1v;
    } vec_t;

    vec_t       q[$];
    int         checks = 0;
    int         errors = 0;
    bit         inc;
    logic [3:0] be;

    function automatic vec_t V(bit r, bit m0r, bit m1r, bit m1w, bit sw, bit srdv, bit ep,
                               bit em0w, bit em1w, bit esr, bit esw, bit em0v, bit em1v);
        vec_t v;
        v.rst = r; v.m0r = m0r; v.m1r = m1r; v.m1w = m1w; v.sw = sw; v.srdv = srdv; v.ep = ep;
        v.e_m0w = em0w; v.e_m1w = em1w; v.e_sr = esr; v.e_sw = esw; v.e_m0v = em0v; v.e_m1v = em1v;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_address = '0; m1_address = '0; m1_writedata = '0; m1_byteenable = '0;
        s_readdata = '0; s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run(input string tag);
        logic [31:0] a0, a1, wd, rd;
        for (int i = 0; i < q.size(); i++) begin
            a0 = 32'h1000_0000 + (inc ? 32'(i * 4) : 32'h0);
            a1 = 32'h2000_0000 + (inc ? 32'(i * 4) : 32'h0);
            wd = 32'hCAFE_0000 + (inc ? 32'(i) : 32'h0);
            rd = 32'hD000_0000 + 32'(i);
            rst = q[i].rst; m0_read = q[i].m0r; m1_read = q[i].m1r; m1_write = q[i].m1w;
            m0_address = a0; m1_address = a1; m1_writedata = wd; m1_byteenable = be;
            s_waitrequest = q[i].sw; s_readdatavalid = q[i].srdv; s_readdata = rd;
            #1;
            if (!q[i].rst) begin
                chk({tag, ".m0_waitrequest"}, i, m0_waitrequest, q[i].e_m0w);
                chk({tag, ".m1_waitrequest"}, i, m1_waitrequest, q[i].e_m1w);
                chk({tag, ".s_read"}, i, s_read, q[i].e_sr);
                chk({tag, ".s_write"}, i, s_write, q[i].e_sw);
                chk({tag, ".m0_readdatavalid"}, i, m0_readdatavalid, q[i].e_m0v);
                chk({tag, ".m1_readdatavalid"}, i, m1_readdatavalid, q[i].e_m1v);
                if (q[i].e_m0v) chk({tag, ".m0_readdata"}, i, m0_readdata, rd);
                if (q[i].e_m1v) chk({tag, ".m1_readdata"}, i, m1_readdata, rd);
                if (q[i].e_sr || q[i].e_sw) begin
                    chk({tag, ".s_address"}, i, s_address, q[i].ep ? a1 : a0);
                    chk({tag, ".s_byteenable"}, i, 32'(s_byteenable), q[i].ep ? 32'(be) : 32'hF);
                end
                if (q[i].e_sw) chk({tag, ".s_writedata"}, i, s_writedata, wd);
            end
            @(posedge clk); #1;
        end
        q.delete();
    endtask

    initial begin
        be = 4'hF; inc = 1'b1;

        // Reset state; a response with an empty tag FIFO is ignored.
        do_reset();
        q.push_back(V(0,0,0,0,0,0,0, 1,1,0,0,0,0));
        q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,0));
        run("reset");

        // Port 0 alone: one idle cycle, then back-to-back re-grants with no gap.
        do_reset();
        for (int i = 0; i < 20; i++)
            q.push_back(i == 0 ? V(0,1,0,0,0,1,0, 1,1,0,0,0,0)
                               : V(0,1,0,0,0,1,0, 0,1,1,0, i >= 2, 0));
        q.push_back(V(0,0,0,0,0,1,0, 0,1,0,0,1,0));
        q.push_back(V(0,0,0,0,0,0,0, 1,1,0,0,0,0));
        run("burst0");

        // Tie from IDLE: port 0 first for 8 beats, then port 1 writes, then back to port 0.
        do_reset(); be = 4'b1010;
        q.push_back(V(0,1,0,1,0,0,0, 1,1,0,0,0,0));
        for (int i = 1; i <= 8; i++) q.push_back(V(0,1,0,1,0,0,0, 0,1,1,0,0,0));
        q.push_back(V(0,1,0,1,0,0,1, 1,0,0,1,0,0));
        q.push_back(V(0,1,0,1,0,0,1, 1,0,0,1,0,0));
        q.push_back(V(0,1,0,0,0,0,1, 1,0,0,0,0,0));
        q.push_back(V(0,1,0,0,0,0,0, 0,1,1,0,0,0));
        q.push_back(V(0,0,0,0,0,0,0, 0,1,0,0,0,0));
        q.push_back(V(0,0,0,0,0,0,0, 1,1,0,0,0,0));
        run("tie");

        // Three port-0 reads then two port-1 reads, data returned 4 cycles after each accept.
        do_reset();
        q.push_back(V(0,1,0,0,0,0,0, 1,1,0,0,0,0));
        for (int i = 1; i <= 3; i++) q.push_back(V(0,1,0,0,0,0,0, 0,1,1,0,0,0));
        q.push_back(V(0,0,1,0,0,0,0, 0,1,0,0,0,0));
        q.push_back(V(0,0,1,0,0,1,1, 1,0,1,0,1,0));
        q.push_back(V(0,0,1,0,0,1,1, 1,0,1,0,1,0));
        q.push_back(V(0,0,0,0,0,1,1, 1,0,0,0,1,0));
        q.push_back(V(0,0,0,0,0,0,0, 1,1,0,0,0,0));
        q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,1));
        q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,1));
        q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,0));
        run("interleave");

        // Tag FIFO fills after 16 reads; one response frees exactly one slot.
        do_reset(); be = 4'hF;
        q.push_back(V(0,1,0,0,0,0,0, 1,1,0,0,0,0));
        for (int i = 1; i <= 16; i++) q.push_back(V(0,1,0,0,0,0,0, 0,1,1,0,0,0));
        q.push_back(V(0,1,0,0,0,0,0, 1,1,0,0,0,0));
        q.push_back(V(0,1,0,0,0,0,0, 1,1,0,0,0,0));
        q.push_back(V(0,1,0,0,0,1,0, 1,1,0,0,1,0));
        q.push_back(V(0,1,0,0,0,0,0, 0,1,1,0,0,0));
        q.push_back(V(0,1,0,0,0,0,0, 1,1,0,0,0,0));
        run("full");

        // Port-1 write stalled 3 cycles: held stable, one accept, no tag pushed.
        do_reset(); be = 4'b0011; inc = 1'b0;
        q.push_back(V(0,0,0,1,0,0,1, 1,1,0,0,0,0));
        for (int i = 1; i <= 3; i++) q.push_back(V(0,0,0,1,1,0,1, 1,1,0,1,0,0));
        q.push_back(V(0,0,0,1,0,0,1, 1,0,0,1,0,0));
        q.push_back(V(0,0,0,0,0,0,1, 1,0,0,0,0,0));
        q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,0));
        run("write");

        // Read and write together on port 1: the read wins and is tagged for port 1.
        do_reset(); be = 4'b1100;
        q.push_back(V(0,0,1,1,0,0,1, 1,1,0,0,0,0));
        q.push_back(V(0,0,1,1,0,0,1, 1,0,1,0,0,0));
        q.push_back(V(0,0,0,0,0,0,0, 1,0,0,0,0,0));
        q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,1));
        run("rdwr");

        // Reset with five reads pending: tags discarded, later responses dropped.
        do_reset(); be = 4'hF; inc = 1'b1;
        q.push_back(V(0,1,0,0,0,0,0, 1,1,0,0,0,0));
        for (int i = 1; i <= 5; i++) q.push_back(V(0,1,0,0,0,0,0, 0,1,1,0,0,0));
        q.push_back(V(1,0,0,0,0,0,0, 0,0,0,0,0,0));
        q.push_back(V(0,0,0,0,0,0,0, 1,1,0,0,0,0));
        for (int i = 0; i < 5; i++) q.push_back(V(0,0,0,0,0,1,0, 1,1,0,0,0,0));
        run("rst_pending");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
